// File: rtl/demux_pkg.sv
// Shared widths and lane/select types for the 1-to-32 word demultiplexer.
package demux_pkg;

    localparam int unsigned DEMUX_DATA_W = 32;
    localparam int unsigned DEMUX_N_OUT  = 32;
    localparam int unsigned DEMUX_SEL_W  = 5;

    typedef logic [DEMUX_DATA_W-1:0] lane_t;
    typedef logic [DEMUX_SEL_W-1:0]  sel_t;

endpackage

// File: rtl/demux_1to32_w32_decoder.sv
// Combinational select decoder: one-hot lane vector, all-zero when the select is out of range.
module decoder_5to32
    import demux_pkg::*;
#(
    parameter int unsigned N_OUT = DEMUX_N_OUT,
    parameter int unsigned SEL_W = DEMUX_SEL_W
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [N_OUT-1:0] onehot_o
);

    logic in_range;

    // Only matters when N_OUT leaves part of the select space unused.
    assign in_range = (32'(sel_i) < N_OUT);

    always_comb begin
        onehot_o = '0;
        if (in_range) begin
            for (int unsigned k = 0; k < N_OUT; k++) begin
                if (32'(sel_i) == k) begin
                    onehot_o[k] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_1to32_w32.sv
// Registered 1-to-N word demultiplexer with one-hot lane-valid flags.
// Build option DEMUX_HOLD_EN: non-selected lanes keep their contents on an enabled edge.
module demux_1to32_w32
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = DEMUX_DATA_W,
    parameter int unsigned N_OUT  = DEMUX_N_OUT,
    parameter int unsigned SEL_W  = DEMUX_SEL_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [SEL_W-1:0]        s,
    input  logic [DATA_W-1:0]       d,
    output logic [N_OUT*DATA_W-1:0] y_arr,
    output logic [N_OUT-1:0]        y_valid
);

    logic [N_OUT-1:0]        valid_d;
    logic [N_OUT-1:0]        y_valid_q;
    logic [N_OUT*DATA_W-1:0] y_arr_d;
    logic [N_OUT*DATA_W-1:0] y_arr_q;

    decoder_5to32 #(
        .N_OUT(N_OUT),
        .SEL_W(SEL_W)
    ) u_dec (
        .sel_i   (s),
        .onehot_o(valid_d)
    );

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
`ifdef DEMUX_HOLD_EN
        assign y_arr_d[k*DATA_W +: DATA_W] = valid_d[k] ? d : y_arr_q[k*DATA_W +: DATA_W];
`else
        assign y_arr_d[k*DATA_W +: DATA_W] = valid_d[k] ? d : '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_arr_q   <= '0;
            y_valid_q <= '0;
        end else if (en) begin
            y_arr_q   <= y_arr_d;
            y_valid_q <= valid_d;
        end
    end

    assign y_arr   = y_arr_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_demux_1to32_w32.sv
// Self-checking bench for demux_1to32_w32: lane-array model plus directed literal checks.
module tb_demux_1to32_w32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [4:0]   s;
    logic [31:0]  d;
    logic [1023:0] y_arr;
    logic [31:0]  y_valid;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    logic [31:0] exp_lane [32];
    logic [31:0] exp_valid;

    demux_1to32_w32 #(.DATA_W(32), .N_OUT(32), .SEL_W(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .s      (s),
        .d      (d),
        .y_arr  (y_arr),
        .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int k);
        return y_arr[k*32 +: 32];
    endfunction

    function automatic logic [31:0] nz_lanes();
        int c = 0;
        for (int k = 0; k < 32; k++) if (y_arr[k*32 +: 32] != 32'h0) c++;
        return 32'(c);
    endfunction

    // Reference: what each lane must hold after the edge, from the routing rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 32; k++) exp_lane[k] = 32'h0;
            exp_valid = 32'h0;
        end else if (en) begin
            for (int k = 0; k < 32; k++) begin
                if (k == int'(s)) exp_lane[k] = d;
`ifndef DEMUX_HOLD_EN
                else exp_lane[k] = 32'h0;
`endif
            end
            exp_valid = 32'h1 << s;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 32; k++) check($sformatf("model_lane%0d", k), lane(k), exp_lane[k]);
            check("model_valid", y_valid, exp_valid);
        end
    end

    always @(posedge clk) begin
        if (rst_n && en) begin
            assert (!$isunknown(s)) else $error("select is X while enabled");
        end
    end

    task automatic apply(input logic e, input logic [4:0] sel, input logic [31:0] data);
        @(negedge clk);
        en = e;
        s  = sel;
        d  = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        s     = 5'($urandom);
        d     = $urandom;
        #2;
        check("rst_nz_lanes", nz_lanes(), 32'd0);
        check("rst_valid", y_valid, 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("rel_nz_lanes", nz_lanes(), 32'd0);
        check("rel_valid", y_valid, 32'h0);
        cmp_on = 1'b1;

        apply(1'b1, 5'd31, 32'h1);
        check("top_lane31", lane(31), 32'h00000001);
        check("top_nz_lanes", nz_lanes(), 32'd1);
        check("top_valid", y_valid, 32'h80000000);

        apply(1'b1, 5'd1, 32'hFFFFFFFF);
        check("sw_lane1", lane(1), 32'hFFFFFFFF);
`ifdef DEMUX_HOLD_EN
        check("sw_lane31", lane(31), 32'h00000001);
`else
        check("sw_lane31", lane(31), 32'h00000000);
`endif
        check("sw_valid", y_valid, 32'h00000002);

        apply(1'b1, 5'd0, 32'hA5A5A5A5);
        repeat (3) apply(1'b0, 5'd7, 32'h12345678);
        check("hold_lane0", lane(0), 32'hA5A5A5A5);
        check("hold_lane7", lane(7), 32'h00000000);
        check("hold_valid", y_valid, 32'h00000001);

        apply(1'b1, 5'd15, 32'hDEADBEEF);
        check("pre_rst_lane15", lane(15), 32'hDEADBEEF);
        check("pre_rst_valid", y_valid, 32'h00008000);
        @(negedge clk);
        en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_nz_lanes", nz_lanes(), 32'd0);
        check("async_valid", y_valid, 32'h0);
        #1 rst_n = 1'b1;

        apply(1'b1, 5'd3, 32'h00000033);
        check("post_rst_lane3", lane(3), 32'h00000033);
        check("post_rst_valid", y_valid, 32'h00000008);

        for (int i = 0; i < 32; i++) begin
            apply(1'b1, 5'(i), 32'h100 + 32'(i));
            check($sformatf("sweep_lane%0d", i), lane(i), 32'h100 + 32'(i));
            check($sformatf("sweep_valid%0d", i), y_valid, 32'h1 << i);
`ifndef DEMUX_HOLD_EN
            check($sformatf("sweep_nz%0d", i), nz_lanes(), 32'd1);
`endif
        end
`ifdef DEMUX_HOLD_EN
        check("sweep_end_nz", nz_lanes(), 32'd32);
`endif

        apply(1'b0, 5'd9, 32'h0BADF00D);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/demux_1to32_w32.md
Name: demux_1to32_w32

Overview:
- Registered 1-to-32 demultiplexer for 32-bit words: routes data input `d` to the output lane chosen by 5-bit select `s`.
- Used in the pipelined MIPS datapath wherever one producer word fans out to one of 32 destinations (e.g. per-register write lanes).
- Outputs are a flat 1024-bit lane array plus a one-hot lane-valid vector, registered on `clk`.

Parameters:
- DATA_W, 32, width of each data lane in bits.
- N_OUT, 32, number of output lanes.
- SEL_W, 5, select width; must equal clog2(N_OUT).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  load enable; when 0, outputs keep their current value.
- s  input  SEL_W  lane select, 0..N_OUT-1.
- d  input  DATA_W  data word to route.
- y_arr  output  N_OUT*DATA_W  lane array; lane k occupies bits [k*DATA_W +: DATA_W].
- y_valid  output  N_OUT  one-hot flag for the lane written on the last enabled cycle.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately regardless of clk): y_arr=0, y_valid=0.
- Latency is 1 cycle. On a rising clk edge with en=1:
  - lane s of y_arr <= d;
  - every other lane <= 0;
  - y_valid <= one-hot(s).
- On a rising clk edge with en=0: y_arr and y_valid hold their values.
- Select decode is full over 0..31; there are no illegal select values at N_OUT=32.
- If parameters give N_OUT < 2^SEL_W and s >= N_OUT: all lanes <= 0 and y_valid <= 0.
- d is passed through unmodified. No arithmetic, no sign handling.
- Changing s and d in the same cycle is legal. Only values sampled at the edge matter.
- Reset asserted mid-stream clears the outputs at once. The first enabled edge after rst_n rises loads normally.
- X on s while en=1 is a usage error. The verification bench flags it with an assertion; the RTL requires no specific behaviour.

Optional Feature:
- Macro: DEMUX_HOLD_EN.
- Defined: on an enabled edge, only lane s is written; non-selected lanes retain their previous contents. y_valid still becomes one-hot(s), so it marks the lane most recently written.
- Undefined (default): non-selected lanes are cleared to 0 on every enabled edge, as described in Behaviour.
- Reset behaviour is identical in both builds.

Decomposition:
- Package demux_pkg holds:
  - localparams DEMUX_DATA_W=32, DEMUX_N_OUT=32, DEMUX_SEL_W=5;
  - typedef lane_t (logic [DEMUX_DATA_W-1:0]);
  - typedef sel_t (logic [DEMUX_SEL_W-1:0]).
- One sub-module, decoder_5to32: purely combinational, maps s to the one-hot N_OUT vector with range check.
- The top level registers the decoder output into y_valid and uses it to gate per-lane writes via a generate loop.

Test Plan:
- Reset: drive rst_n=0 with random s/d, no clock -> y_arr==0, y_valid==0 immediately. Release reset, no clock edge -> outputs still 0.
- Top lane: s=5'b11111, d=32'h1, en=1, one edge -> lane 31 == 32'h00000001, lanes 0..30 == 0, y_valid == 32'h80000000.
- Lane switch: then s=5'b00001, d=32'hFFFFFFFF, one edge:
  - default build: lane 1 == 32'hFFFFFFFF, lane 31 == 0, y_valid == 32'h00000002;
  - DEMUX_HOLD_EN build: lane 31 stays 32'h1.
- Enable low: load s=0, d=32'hA5A5A5A5. Then en=0 with s=7, d=32'h12345678 for 3 edges -> lane 0 still 32'hA5A5A5A5, lane 7 == 0, y_valid == 32'h1.
- Async reset mid-operation: after loading lane 15 with 32'hDEADBEEF, pulse rst_n low between clock edges -> all outputs 0 before the next edge.
- Sweep: s=0..31 with d = 32'h100 + s on consecutive edges -> after each edge only lane s is nonzero (default build) and equals 32'h100 + s; y_valid == (1 << s).
